eth_rx_buf: RTL and testbench
=============================

# eth_rx_buf

Receive frame buffer placed directly downstream of the RMII MAC receiver. It consumes the receiver's byte stream (`rx_vld`/`rx_data`/`rx_addr`) and the end-of-frame qualifiers, and writes each frame into one of two 2 KB banks. After the frame ends, it filters the frame on status, length and destination MAC address. Good frames are presented to the packet consumer through a random-access read port with a ready/ack handshake.

## Interface
- `MIN_LEN`, 64: minimum accepted frame length in bytes, FCS included.
- `MAX_LEN`, 1518: maximum accepted frame length in bytes, FCS included; must be ≤ 2047.
- `clk` in 1: system clock, 100 MHz.
- `reset` in 1: synchronous, active-high.
- `rx_vld` in 1: one-cycle byte strobe from the receiver.
- `rx_last` in 1: with `rx_vld`, marks the final byte of the frame.
- `rx_err` in 1: receiver frame error; level signal, holds until the receiver returns to idle.
- `rx_crc_ok` in 1: FCS check result; meaningful in the `rx_vld & rx_last` cycle.
- `rx_addr` in 11: byte index within the frame, valid with `rx_vld`.
- `rx_data` in 8: received byte, valid with `rx_vld`.
- `my_mac` in 48: station address; `my_mac[47:40]` is the first byte on the wire.
- `frm_rdy` out 1: a good frame is available on the read port.
- `frm_len` out 11: payload length of the presented frame, FCS excluded; valid while `frm_rdy`.
- `frm_bcast` out 1: the presented frame's destination is FF:FF:FF:FF:FF:FF.
- `frm_ack` in 1: one-cycle pulse that releases the presented frame; ignored when `frm_rdy`=0.
- `rd_addr` in 11: read byte address within the presented frame.
- `rd_data` out 8: byte at `rd_addr`, returned with one cycle of latency.
- `frm_cnt` out 16: count of accepted frames; saturates at 0xFFFF.
- `drop_cnt` out 16: count of dropped frames; saturates at 0xFFFF.

## Operation
- Storage is two banks of 2048×8 bytes, with one write port (writer) and one synchronous read port (reader). Each bank is in one of three states: FREE, FILL or FULL.
- The writer FSM has three states: W_IDLE, W_FILL and W_DISC.
  - W_IDLE: waits for `rx_vld & rx_addr==0 & ~rx_err`. If the next bank in ring order is FREE, the writer marks it FILL, writes the byte and goes to W_FILL. Otherwise it goes to W_DISC with reason "overflow".
  - W_FILL: each `rx_vld` writes `rx_data` to bank[`rx_addr`].
    - Bytes 0..5 are compared against `my_mac` and against all-ones, and two match flags are accumulated.
    - If `rx_addr` ≥ `MAX_LEN`, the writer goes to W_DISC.
  - W_DISC: takes no writes. On `rx_vld & rx_last` it counts one drop and returns to W_IDLE.
- Abort: `rx_err`=1 while in W_FILL or W_DISC drops the frame immediately. The bank returns to FREE, `drop_cnt` increments and the writer returns to W_IDLE. W_IDLE ignores all bytes while `rx_err`=1.
- `rx_vld & rx_addr==0` while in W_FILL means the previous frame was truncated. The writer drops it, reuses the same bank and starts the new frame in the same cycle.
- End of frame is `rx_vld & rx_last` in W_FILL, with total length L = `rx_addr`+1. The frame is accepted only when all of the following hold:
  - `rx_crc_ok`=1 and `rx_err`=0;
  - `MIN_LEN` ≤ L ≤ `MAX_LEN`;
  - the destination matches (see Configuration).
- Accepted frame: the bank becomes FULL, its stored length is L−4, `frm_cnt` increments, and the broadcast flag is stored with the bank. Rejected frame: the bank becomes FREE and `drop_cnt` increments.
- Reader: presents the oldest FULL bank, since banks commit in ring order.
  - `frm_ack` with `frm_rdy`=1 sets that bank to FREE, and `frm_rdy` drops the next cycle.
  - If the other bank is FULL, `frm_rdy` reasserts after exactly one low cycle.
- `rd_addr` beyond `frm_len` returns don't-care data; reads have no side effects.

## Timing
- Reset values: `frm_rdy`=0, `frm_len`=0, `frm_bcast`=0, `rd_data`=0, `frm_cnt`=0, `drop_cnt`=0. Both banks are FREE and the writer is in W_IDLE. RAM contents are not reset.
- Reset asserted mid-frame discards everything. The next frame is accepted only from a fresh `rx_addr==0`.
- Commit latency: `frm_rdy`, `frm_len` and `frm_bcast` are valid in the cycle after the `rx_vld & rx_last` cycle.
- Counters update in the cycle after the accept/drop decision.
- Read latency: `rd_data` reflects the `rd_addr` sampled one clock earlier.
- Commit and `frm_ack` in the same cycle: both take effect. The newly committed bank is presented after the one low cycle.
- Writer start and reader release in the same cycle: the bank being released is not yet FREE in that cycle, so the start is an overflow drop.
- Bytes arrive at most every 8 cycles. Consecutive frames have no minimum gap requirement.

## Configuration
- `ETH_RX_PROMISC_EN` undefined: a frame passes the destination check only if its destination equals `my_mac` or equals broadcast. A failing frame counts as a drop.
- `ETH_RX_PROMISC_EN` defined: the destination comparison against `my_mac` is not built and every frame passes the destination check. `frm_bcast` is still computed and reported.

## Test plan
- 64-byte frame, destination = `my_mac` = 02:00:00:00:00:01, `rx_crc_ok`=1 -> `frm_rdy` one cycle after last byte, `frm_len`=60, `frm_bcast`=0, `frm_cnt`=1; reads at addresses 0..59 return the sent bytes one cycle later.
- Broadcast 100-byte frame -> `frm_len`=96, `frm_bcast`=1. Same frame with `rx_crc_ok`=0 -> no `frm_rdy`, `drop_cnt`=1.
- Three back-to-back good frames with no `frm_ack` -> first two held FULL, third dropped as overflow (`drop_cnt`=1). After `frm_ack`: `frm_rdy` low for one cycle, then the second frame is presented.
- `rx_err` raised at byte 20 of a 200-byte frame, then a good 64-byte frame -> first dropped, second accepted, `frm_len`=60.
- 60-byte frame and 1519-byte frame -> both dropped, `drop_cnt`=2. Unicast to 02:00:00:00:00:02 -> dropped without `ETH_RX_PROMISC_EN`, accepted with it.
- `reset` pulsed mid-frame and while `frm_rdy`=1 -> all outputs return to reset values; the following good frame is accepted normally.

Source files
------------

// File: rtl/eth_rx_buf.sv
// Two-bank receive frame buffer: stores RMII receiver frames, filters on status/length/destination.
// Build option: define ETH_RX_PROMISC_EN to skip the station-address check (every destination passes).
module eth_rx_buf #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_vld,
    input  logic        rx_last,
    input  logic        rx_err,
    input  logic        rx_crc_ok,
    input  logic [10:0] rx_addr,
    input  logic [7:0]  rx_data,
    input  logic [47:0] my_mac,
    output logic        frm_rdy,
    output logic [10:0] frm_len,
    output logic        frm_bcast,
    input  logic        frm_ack,
    input  logic [10:0] rd_addr,
    output logic [7:0]  rd_data,
    output logic [15:0] frm_cnt,
    output logic [15:0] drop_cnt
);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DISC} wr_state_e;
    typedef enum logic [1:0] {B_FREE, B_FILL, B_FULL} bank_state_e;

    localparam logic [11:0] MIN_L = 12'(MIN_LEN);
    localparam logic [11:0] MAX_L = 12'(MAX_LEN);

    wr_state_e   wr_state_q, wr_state_d;
    bank_state_e bank_st_q  [2];
    bank_state_e bank_st_d  [2];
    logic [10:0] bank_len_q [2];
    logic [10:0] bank_len_d [2];
    logic        bank_bc_q  [2];
    logic        bank_bc_d  [2];
    logic        wr_bank_q, wr_bank_d;
    logic        rd_bank_q, rd_bank_d;
    logic        ucast_q, ucast_d;
    logic        bcast_q, bcast_d;
    logic        frm_rdy_q, frm_rdy_d;
    logic [10:0] frm_len_q, frm_len_d;
    logic        frm_bcast_q, frm_bcast_d;
    logic [15:0] frm_cnt_q, frm_cnt_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;
    logic [7:0]  rd_data_q;

    logic [7:0]  mem [0:4095];
    logic        wr_en;
    logic [11:0] wr_addr;
    logic        frm_inc;
    logic        drop_inc;
    logic        ack_take;
    logic        ucast_hit;
    logic        bcast_hit;
    logic        dest_ok;
    logic [11:0] rx_len;

    assign bcast_hit = (rx_data == 8'hFF);
    assign dest_ok   = ucast_q | bcast_q;

`ifdef ETH_RX_PROMISC_EN
    assign ucast_hit = 1'b1;
`else
    logic [7:0] mac_byte;

    always_comb begin
        mac_byte = 8'h00;
        case (rx_addr[2:0])
            3'd0:    mac_byte = my_mac[47:40];
            3'd1:    mac_byte = my_mac[39:32];
            3'd2:    mac_byte = my_mac[31:24];
            3'd3:    mac_byte = my_mac[23:16];
            3'd4:    mac_byte = my_mac[15:8];
            3'd5:    mac_byte = my_mac[7:0];
            default: mac_byte = 8'h00;
        endcase
    end

    assign ucast_hit = (rx_data == mac_byte);
`endif

    assign rx_len   = {1'b0, rx_addr} + 12'd1;
    assign ack_take = frm_ack & frm_rdy_q;
    assign wr_addr  = {wr_bank_q, rx_addr};

    always_comb begin
        wr_state_d = wr_state_q;
        for (int i = 0; i < 2; i++) begin
            bank_st_d[i]  = bank_st_q[i];
            bank_len_d[i] = bank_len_q[i];
            bank_bc_d[i]  = bank_bc_q[i];
        end
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        ucast_d   = ucast_q;
        bcast_d   = bcast_q;
        wr_en     = 1'b0;
        frm_inc   = 1'b0;
        drop_inc  = 1'b0;

        // Release uses the registered bank state, so a same-cycle writer start sees it still FULL.
        if (ack_take) begin
            bank_st_d[rd_bank_q] = B_FREE;
            rd_bank_d            = ~rd_bank_q;
        end

        case (wr_state_q)
            W_IDLE: begin
                if (rx_vld && rx_addr == 11'd0 && !rx_err) begin
                    if (rx_last) begin
                        drop_inc = 1'b1;
                    end else if (bank_st_q[wr_bank_q] == B_FREE) begin
                        bank_st_d[wr_bank_q] = B_FILL;
                        wr_en      = 1'b1;
                        ucast_d    = ucast_hit;
                        bcast_d    = bcast_hit;
                        wr_state_d = W_FILL;
                    end else begin
                        wr_state_d = W_DISC;
                    end
                end
            end
            W_FILL: begin
                if (rx_err) begin
                    bank_st_d[wr_bank_q] = B_FREE;
                    drop_inc   = 1'b1;
                    wr_state_d = W_IDLE;
                end else if (rx_vld) begin
                    if (rx_addr == 11'd0) begin
                        // Truncated frame: restart in the same bank with this byte.
                        drop_inc = 1'b1;
                        wr_en    = 1'b1;
                        ucast_d  = ucast_hit;
                        bcast_d  = bcast_hit;
                    end else if (rx_last) begin
                        wr_en      = 1'b1;
                        wr_state_d = W_IDLE;
                        if (rx_crc_ok && rx_len >= MIN_L && rx_len <= MAX_L && dest_ok) begin
                            bank_st_d[wr_bank_q]  = B_FULL;
                            bank_len_d[wr_bank_q] = rx_len[10:0] - 11'd4;
                            bank_bc_d[wr_bank_q]  = bcast_q;
                            wr_bank_d             = ~wr_bank_q;
                            frm_inc               = 1'b1;
                        end else begin
                            bank_st_d[wr_bank_q] = B_FREE;
                            drop_inc             = 1'b1;
                        end
                    end else if ({1'b0, rx_addr} >= MAX_L) begin
                        bank_st_d[wr_bank_q] = B_FREE;
                        wr_state_d           = W_DISC;
                    end else begin
                        wr_en = 1'b1;
                        if (rx_addr < 11'd6) begin
                            ucast_d = ucast_q & ucast_hit;
                            bcast_d = bcast_q & bcast_hit;
                        end
                    end
                end
            end
            W_DISC: begin
                if (rx_err || (rx_vld && rx_last)) begin
                    drop_inc   = 1'b1;
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase

        // Presentation follows next-cycle bank state so a commit shows up one cycle after the last byte.
        frm_rdy_d   = (bank_st_d[rd_bank_d] == B_FULL) & ~ack_take;
        frm_len_d   = frm_rdy_d ? bank_len_d[rd_bank_d] : 11'd0;
        frm_bcast_d = frm_rdy_d ? bank_bc_d[rd_bank_d] : 1'b0;

        frm_cnt_d  = (frm_inc && frm_cnt_q != 16'hFFFF) ? frm_cnt_q + 16'd1 : frm_cnt_q;
        drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q    <= W_IDLE;
            bank_st_q[0]  <= B_FREE;
            bank_st_q[1]  <= B_FREE;
            bank_len_q[0] <= 11'd0;
            bank_len_q[1] <= 11'd0;
            bank_bc_q[0]  <= 1'b0;
            bank_bc_q[1]  <= 1'b0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            ucast_q       <= 1'b0;
            bcast_q       <= 1'b0;
            frm_rdy_q     <= 1'b0;
            frm_len_q     <= 11'd0;
            frm_bcast_q   <= 1'b0;
            frm_cnt_q     <= 16'd0;
            drop_cnt_q    <= 16'd0;
        end else begin
            wr_state_q    <= wr_state_d;
            bank_st_q[0]  <= bank_st_d[0];
            bank_st_q[1]  <= bank_st_d[1];
            bank_len_q[0] <= bank_len_d[0];
            bank_len_q[1] <= bank_len_d[1];
            bank_bc_q[0]  <= bank_bc_d[0];
            bank_bc_q[1]  <= bank_bc_d[1];
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            ucast_q       <= ucast_d;
            bcast_q       <= bcast_d;
            frm_rdy_q     <= frm_rdy_d;
            frm_len_q     <= frm_len_d;
            frm_bcast_q   <= frm_bcast_d;
            frm_cnt_q     <= frm_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Frame storage: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= mem[{rd_bank_q, rd_addr}];
        end
    end

    assign frm_rdy   = frm_rdy_q;
    assign frm_len   = frm_len_q;
    assign frm_bcast = frm_bcast_q;
    assign rd_data   = rd_data_q;
    assign frm_cnt   = frm_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_buf.sv
// Directed bench for eth_rx_buf: frame scoreboard on read-port bytes plus status/counter checks.
module tb_eth_rx_buf;
  localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST  = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [47:0] OTHER  = 48'h02_00_00_00_00_02;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rx_vld, rx_last, rx_err, rx_crc_ok;
  logic [10:0] rx_addr;
  logic [7:0]  rx_data;
  logic [47:0] my_mac;
  logic        frm_rdy;
  logic [10:0] frm_len;
  logic        frm_bcast;
  logic        frm_ack;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic [15:0] frm_cnt, drop_cnt;

  eth_rx_buf dut (
    .clk(clk), .reset(reset),
    .rx_vld(rx_vld), .rx_last(rx_last), .rx_err(rx_err), .rx_crc_ok(rx_crc_ok),
    .rx_addr(rx_addr), .rx_data(rx_data), .my_mac(my_mac),
    .frm_rdy(frm_rdy), .frm_len(frm_len), .frm_bcast(frm_bcast), .frm_ack(frm_ack),
    .rd_addr(rd_addr), .rd_data(rd_data), .frm_cnt(frm_cnt), .drop_cnt(drop_cnt)
  );

  // scoreboard
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int exp_frm = 0;
  int exp_drop = 0;
  logic rdy_before_last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // driver: bytes start..len-1, one strobe per 8 cycles; cut_at stops early (optionally with rx_err)
  task automatic send_frame(input logic [47:0] dst, input int len, input bit crc, input int start,
                            input int cut_at, input bit cut_err, input bit keep);
    logic [7:0] b;
    for (int i = start; i < len; i++) begin
      if (i == cut_at) begin
        if (cut_err) begin
          rx_err = 1'b1;
          tick(4);
          rx_err = 1'b0;
          tick(2);
        end
        break;
      end
      if (i < 6) b = dst[47 - 8*i -: 8];
      else b = 8'($urandom_range(0, 255));
      if (keep && i < len - 4) exp_q.push_back(b);
      rx_vld    = 1'b1;
      rx_addr   = 11'(i);
      rx_data   = b;
      rx_last   = (i == len - 1);
      rx_crc_ok = crc && (i == len - 1);
      if (i == len - 1) rdy_before_last = frm_rdy;
      @(negedge clk);
      rx_vld    = 1'b0;
      rx_last   = 1'b0;
      rx_crc_ok = 1'b0;
      if (i != len - 1) tick(7);
    end
  endtask

  task automatic read_check(input int n, input string tag);
    logic [7:0] e;
    for (int i = 0; i < n; i++) begin
      rd_addr = 11'(i);
      @(negedge clk);
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL %s_empty: observed no expected byte, required one at addr %0d", tag, i);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check(tag, 32'(rd_data), 32'(e));
      end
    end
  endtask

  task automatic ack_frame();
    frm_ack = 1'b1;
    @(negedge clk);
    frm_ack = 1'b0;
  endtask

  task automatic check_status(input string tag, input logic rdy, input int len, input logic bc);
    check({tag, "_rdy"}, 32'(frm_rdy), 32'(rdy));
    if (rdy) begin
      check({tag, "_len"}, 32'(frm_len), 32'(len));
      check({tag, "_bcast"}, 32'(frm_bcast), 32'(bc));
    end
    check({tag, "_frm_cnt"}, 32'(frm_cnt), 32'(exp_frm));
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 32'(exp_drop));
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rdy"}, 32'(frm_rdy), 0);
    check({tag, "_len"}, 32'(frm_len), 0);
    check({tag, "_bcast"}, 32'(frm_bcast), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
    check({tag, "_frm_cnt"}, 32'(frm_cnt), 0);
    check({tag, "_drop_cnt"}, 32'(drop_cnt), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, required finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rx_vld = 1'b0; rx_last = 1'b0; rx_err = 1'b0; rx_crc_ok = 1'b0;
    rx_addr = '0; rx_data = '0; my_mac = MY_MAC; frm_ack = 1'b0; rd_addr = '0;
    rdy_before_last = 1'b0;
    tick(3);
    check_reset_vals("reset");
    reset = 1'b0;
    tick(2);

    // 64-byte unicast to my_mac
    send_frame(MY_MAC, 64, 1, 0, -1, 0, 1);
    exp_frm++;
    check("t1_rdy_early", 32'(rdy_before_last), 0);
    check_status("t1", 1, 60, 0);
    read_check(60, "t1_rd");
    ack_frame();
    check("t1_ack_rdy", 32'(frm_rdy), 0);
    tick(1);
    check("t1_ack_rdy2", 32'(frm_rdy), 0);

    // broadcast 100-byte, then same with bad FCS
    send_frame(BCAST, 100, 1, 0, -1, 0, 1);
    exp_frm++;
    check_status("t2", 1, 96, 1);
    read_check(96, "t2_rd");
    ack_frame();
    check("t2_ack_rdy", 32'(frm_rdy), 0);
    send_frame(BCAST, 100, 0, 0, -1, 0, 0);
    exp_drop++;
    check_status("t2_crc", 0, 0, 0);

    // three back-to-back frames, third overflows
    send_frame(MY_MAC, 64, 1, 0, -1, 0, 1);
    send_frame(MY_MAC, 70, 1, 0, -1, 0, 1);
    send_frame(MY_MAC, 80, 1, 0, -1, 0, 0);
    exp_frm += 2;
    exp_drop++;
    check_status("t3_a", 1, 60, 0);
    read_check(60, "t3_rd_a");
    ack_frame();
    check("t3_gap_rdy", 32'(frm_rdy), 0);
    tick(1);
    check_status("t3_b", 1, 66, 0);
    read_check(66, "t3_rd_b");
    ack_frame();
    check("t3_b_ack_rdy", 32'(frm_rdy), 0);

    // rx_err abort at byte 20, then good frame
    send_frame(MY_MAC, 200, 1, 0, 20, 1, 0);
    exp_drop++;
    check_status("t4_err", 0, 0, 0);
    send_frame(MY_MAC, 64, 1, 0, -1, 0, 1);
    exp_frm++;
    check_status("t4_good", 1, 60, 0);
    read_check(60, "t4_rd");
    ack_frame();

    // length limits and foreign unicast
    send_frame(MY_MAC, 60, 1, 0, -1, 0, 0);
    exp_drop++;
    send_frame(MY_MAC, 1519, 1, 0, -1, 0, 0);
    exp_drop++;
    check_status("t5_len", 0, 0, 0);
`ifdef ETH_RX_PROMISC_EN
    send_frame(OTHER, 64, 1, 0, -1, 0, 1);
    exp_frm++;
    check_status("t5_other", 1, 60, 0);
    read_check(60, "t5_rd");
    ack_frame();
`else
    send_frame(OTHER, 64, 1, 0, -1, 0, 0);
    exp_drop++;
    check_status("t5_other", 0, 0, 0);
`endif

    // reset mid-frame; the tail of that frame must be ignored
    send_frame(MY_MAC, 64, 1, 0, 30, 0, 0);
    reset = 1'b1;
    tick(2);
    check_reset_vals("t6_mid");
    reset = 1'b0;
    exp_frm = 0;
    exp_drop = 0;
    send_frame(MY_MAC, 64, 1, 30, -1, 0, 0);
    check_status("t6_tail", 0, 0, 0);

    // reset while a frame is presented
    send_frame(MY_MAC, 64, 1, 0, -1, 0, 0);
    exp_frm++;
    check_status("t6_pre", 1, 60, 0);
    reset = 1'b1;
    tick(2);
    check_reset_vals("t6_rdy");
    reset = 1'b0;
    exp_frm = 0;
    tick(2);
    send_frame(BCAST, 64, 1, 0, -1, 0, 1);
    exp_frm++;
    check_status("t6_post", 1, 60, 1);
    read_check(60, "t6_rd");
    ack_frame();
    check("t6_ack_rdy", 32'(frm_rdy), 0);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
